// File: rtl/race_pkg.sv
// Shared types and helpers for race-logic (temporal) cells.
package race_pkg;

    typedef enum logic [1:0] {
        RM_IDLE,
        RM_ARMED,
        RM_FIRED
    } race_min_state_t;

    localparam logic POL_RISE = 1'b0;
    localparam logic POL_FALL = 1'b1;

    // All-ones code meaning "never arrived".
    function automatic logic [63:0] time_inf(input int unsigned tw);
        return (64'd1 << tw) - 64'd1;
    endfunction

    function automatic int unsigned lowest_set_idx(input logic [63:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/race_gamma_timer.sv
// Gamma-window counter: clear has priority over enable, flags terminal count.
module race_gamma_timer #(
    parameter int TW = 8,
    parameter int TC = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [TW-1:0] cnt_o,
    output logic          tc_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TW'(TC));

endmodule

// File: rtl/race_min_n.sv
// N-input first-arrival (min) cell for race logic, windowed by gamma_start.
module race_min_n
    import race_pkg::*;
#(
    parameter int N         = 4,
    parameter int TW        = 8,
    parameter int GAMMA_LEN = 16,
    parameter int POLARITY  = 0,
    localparam int IDXW     = (N > 2) ? $clog2(N) : 1
) (
    input  logic            aclk,
    input  logic            grst,
    input  logic            gamma_start,
    input  logic [N-1:0]    in,
    output logic            y,
    output logic [TW-1:0]   y_time,
    output logic [IDXW-1:0] win_idx,
    output logic [N-1:0]    tie_mask,
    output logic            win_valid,
    output logic            done
);

    if (N < 2 || GAMMA_LEN < 2 || GAMMA_LEN - 1 >= (2 ** TW) - 1) begin : g_bad_cfg
        $error("race_min_n: N/GAMMA_LEN/TW configuration out of range");
    end

    localparam logic          POL = (POLARITY != 0) ? POL_FALL : POL_RISE;
    localparam logic [TW-1:0] INF = TW'(time_inf(TW));

    race_min_state_t  state_q;
    logic             y_q;
    logic [TW-1:0]    y_time_q;
    logic [IDXW-1:0]  win_idx_q;
    logic [N-1:0]     tie_mask_q;
    logic             win_valid_q;
    logic             done_q;

    logic [N-1:0]    act_d;
    logic [IDXW-1:0] first_d;
    logic [TW-1:0]   timer;
    logic            tc;
    logic            run;

    assign act_d   = in ^ {N{POL}};
    assign first_d = IDXW'(lowest_set_idx(64'(act_d)));
    assign run     = (state_q != RM_IDLE);

    race_gamma_timer #(
        .TW (TW),
        .TC (GAMMA_LEN - 1)
    ) u_timer (
        .clk_i (aclk),
        .rst_i (grst),
        .clr_i (gamma_start | ~run | tc),
        .en_i  (run),
        .cnt_o (timer),
        .tc_o  (tc)
    );

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q     <= RM_IDLE;
            y_q         <= POL;
            y_time_q    <= INF;
            win_idx_q   <= '0;
            tie_mask_q  <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (gamma_start) begin
                // A new window pre-empts capture and window end alike.
                state_q     <= RM_ARMED;
                y_q         <= POL;
                y_time_q    <= INF;
                win_idx_q   <= '0;
                tie_mask_q  <= '0;
                win_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    RM_ARMED: begin
                        if (act_d != '0) begin
                            state_q     <= RM_FIRED;
                            y_q         <= ~POL;
                            y_time_q    <= timer;
                            win_idx_q   <= first_d;
                            tie_mask_q  <= act_d;
                            win_valid_q <= 1'b1;
                        end
                        if (tc) begin
                            state_q <= RM_IDLE;
                            y_q     <= POL;
                            done_q  <= 1'b1;
                        end
                    end
                    RM_FIRED: begin
                        if (tc) begin
                            state_q <= RM_IDLE;
                            y_q     <= POL;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= RM_IDLE;
                endcase
            end
        end
    end

    assign y         = y_q;
    assign y_time    = y_time_q;
    assign win_idx   = win_idx_q;
    assign tie_mask  = tie_mask_q;
    assign win_valid = win_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_race_min_n.sv
// Bench for race_min_n: both polarities driven from one activity vector.
module tb_race_min_n;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int G  = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         grst;
    logic         gamma_start;
    logic [N-1:0] act;
    logic [N-1:0] in0;
    logic [N-1:0] in1;

    assign in0 = act;
    assign in1 = ~act;

    logic          y0, y1, v0, v1, d0, d1;
    logic [TW-1:0] t0, t1;
    logic [IW-1:0] i0, i1;
    logic [N-1:0]  k0, k1;

    race_min_n #(.N(N), .TW(TW), .GAMMA_LEN(G), .POLARITY(0)) u_rise (
        .aclk(clk), .grst(grst), .gamma_start(gamma_start), .in(in0),
        .y(y0), .y_time(t0), .win_idx(i0), .tie_mask(k0),
        .win_valid(v0), .done(d0)
    );

    race_min_n #(.N(N), .TW(TW), .GAMMA_LEN(G), .POLARITY(1)) u_fall (
        .aclk(clk), .grst(grst), .gamma_start(gamma_start), .in(in1),
        .y(y1), .y_time(t1), .win_idx(i1), .tie_mask(k1),
        .win_valid(v1), .done(d1)
    );

    int total = 0;
    int bad   = 0;

    // Reference: window bookkeeping in plain integers.
    bit           m_open;
    int           m_t;
    bit           m_y;
    bit           m_valid;
    bit           m_done;
    int           m_time;
    int           m_idx;
    logic [N-1:0] m_tie;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", nm, a, e, $time);
        end
    endtask

    task automatic model_clear();
        m_y     = 1'b0;
        m_valid = 1'b0;
        m_time  = 255;
        m_idx   = 0;
        m_tie   = '0;
    endtask

    task automatic model_step(input bit rst, input bit st, input logic [N-1:0] a);
        if (rst) begin
            m_open = 1'b0;
            m_t    = 0;
            m_done = 1'b0;
            model_clear();
        end else begin
            m_done = 1'b0;
            if (st) begin
                m_open = 1'b1;
                m_t    = 0;
                model_clear();
            end else if (m_open) begin
                if (!m_valid && a != '0) begin
                    m_valid = 1'b1;
                    m_y     = 1'b1;
                    m_time  = m_t;
                    m_tie   = a;
                    for (int c = N - 1; c >= 0; c--) if (a[c]) m_idx = c;
                end
                if (m_t == G - 1) begin
                    m_open = 1'b0;
                    m_done = 1'b1;
                    m_y    = 1'b0;
                end
                m_t++;
            end
        end
    endtask

    task automatic compare_all();
        chk("y_rise", 32'(y0), 32'(m_y));
        chk("y_fall", 32'(y1), 32'(!m_y));
        chk("time_rise", 32'(t0), m_time);
        chk("time_fall", 32'(t1), m_time);
        chk("idx_rise", 32'(i0), m_idx);
        chk("idx_fall", 32'(i1), m_idx);
        chk("tie_rise", 32'(k0), 32'(m_tie));
        chk("tie_fall", 32'(k1), 32'(m_tie));
        chk("valid_rise", 32'(v0), 32'(m_valid));
        chk("valid_fall", 32'(v1), 32'(m_valid));
        chk("done_rise", 32'(d0), 32'(m_done));
        chk("done_fall", 32'(d1), 32'(m_done));
    endtask

    task automatic cycle(input bit rst, input bit st, input logic [N-1:0] a);
        grst        = rst;
        gamma_start = st;
        act         = a;
        @(posedge clk);
        model_step(rst, st, a);
        #1;
        compare_all();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_y_rise"}, 32'(y0), 32'd0);
        chk({nm, "_y_fall"}, 32'(y1), 32'd1);
        chk({nm, "_time"}, 32'(t0), 32'hFF);
        chk({nm, "_idx"}, 32'(i0), 32'd0);
        chk({nm, "_tie"}, 32'(k0), 32'd0);
        chk({nm, "_valid"}, 32'(v0), 32'd0);
        chk({nm, "_done"}, 32'(d0), 32'd0);
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] m1;
        int           at1;
        logic [N-1:0] m2;
        int           at2;
        int           e_time;
        int           e_idx;
        logic [N-1:0] e_tie;
        bit           e_valid;
    } vec_t;

    vec_t vec[6];

    initial begin
        logic [N-1:0] a;
        grst        = 1'b1;
        gamma_start = 1'b0;
        act         = '0;

        vec[0] = '{"none",    4'b0000, 0,  4'b0000, 99, 255, 0, 4'b0000, 1'b0};
        vec[1] = '{"ordered", 4'b0100, 3,  4'b0001, 7,  3,   2, 4'b0100, 1'b1};
        vec[2] = '{"tie",     4'b1010, 5,  4'b0000, 99, 5,   1, 4'b1010, 1'b1};
        vec[3] = '{"preact",  4'b0001, -1, 4'b0000, 99, 0,   0, 4'b0001, 1'b1};
        vec[4] = '{"last",    4'b1000, 15, 4'b0000, 99, 15,  3, 4'b1000, 1'b1};
        vec[5] = '{"all",     4'b1111, 0,  4'b0010, 1,  0,   0, 4'b1111, 1'b1};

        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        chk_reset_vals("reset");
        cycle(1'b0, 1'b0, 4'b1111);
        chk("idle_ignores_in", 32'(v0), 32'd0);

        foreach (vec[e]) begin
            cycle(1'b0, 1'b1, (vec[e].at1 < 0) ? vec[e].m1 : '0);
            for (int t = 0; t < G; t++) begin
                a = (t >= vec[e].at1 ? vec[e].m1 : '0) | (t >= vec[e].at2 ? vec[e].m2 : '0);
                cycle(1'b0, 1'b0, a);
            end
            chk({vec[e].name, "_done"}, 32'(d0), 32'd1);
            chk({vec[e].name, "_time"}, 32'(t0), vec[e].e_time);
            chk({vec[e].name, "_idx"}, 32'(i1), vec[e].e_idx);
            chk({vec[e].name, "_tie"}, 32'(k1), 32'(vec[e].e_tie));
            chk({vec[e].name, "_valid"}, 32'(v0), 32'(vec[e].e_valid));
            chk({vec[e].name, "_y_end"}, 32'(y1), 32'd1);
            cycle(1'b0, 1'b0, '0);
        end

        // Abort mid-window after a fire, then a fresh window.
        cycle(1'b0, 1'b1, '0);
        for (int t = 0; t < 4; t++) cycle(1'b0, 1'b0, '0);
        for (int t = 4; t < 9; t++) cycle(1'b0, 1'b0, 4'b0100);
        chk("abort_pre_y", 32'(y0), 32'd1);
        cycle(1'b0, 1'b1, 4'b0100);
        chk("abort_y", 32'(y0), 32'd0);
        chk("abort_time", 32'(t0), 32'hFF);
        chk("abort_valid", 32'(v1), 32'd0);
        chk("abort_done", 32'(d0), 32'd0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 4'b0010);
        chk("rewin_time", 32'(t0), 32'd2);
        chk("rewin_idx", 32'(i0), 32'd1);

        // Reset at time 2 of a window.
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 4'b0001);
        chk_reset_vals("midrst");

        // Reset beats start: window stays closed.
        cycle(1'b1, 1'b1, '0);
        cycle(1'b0, 1'b0, 4'b0001);
        chk("rst_beats_start", 32'(v0), 32'd0);

        // Start on the terminal edge: no done, new window opens.
        cycle(1'b0, 1'b1, '0);
        for (int t = 0; t < G - 1; t++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 4'b1000);
        chk("start_vs_end_done", 32'(d0), 32'd0);
        cycle(1'b0, 1'b0, 4'b1000);
        chk("start_vs_end_fire", 32'(t0), 32'd0);
        for (int t = 1; t < G; t++) cycle(1'b0, 1'b0, '0);

        for (int n = 0; n < 600; n++) begin
            a = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
